// File: rtl/fp32_sub_if.sv
// fp32_sub_if: valid/ready operand and result channels of the sequential FP32 subtractor.
// master = issuing side (drives operands, accepts result), slave = the subtractor.
interface fp32_sub_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] input_01;
  logic [DATA_WIDTH-1:0] input_02;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result_sub;
  logic                  busy;

  modport master (
    output in_valid, input_01, input_02, out_ready,
    input  in_ready, out_valid, result_sub, busy
  );

  modport slave (
    input  in_valid, input_01, input_02, out_ready,
    output in_ready, out_valid, result_sub, busy
  );
endinterface

// File: rtl/fp32_sub_seq.sv
// fp32_sub_seq: multi-cycle IEEE-754 single-precision subtractor, result_sub = input_01 - input_02.
// Flow: IDLE -> ALIGN -> ARITH -> NORM (one left shift per cycle) -> DONE.
// Optional feature macro FP_SUB_ROUND_EN: carries guard/round/sticky bits through the datapath
// and rounds to nearest even in an extra ROUND cycle; without it alignment truncates.
module fp32_sub_seq #(
  parameter int DATA_WIDTH         = 32,
  parameter int EXP_WIDTH          = 8,
  parameter int SIGNIFICANDS_WIDTH = 23,
  parameter int ADDER_WIDTH        = 25
) (
  input logic       clk,
  input logic       rst,
  fp32_sub_if.slave bus
);

`ifdef FP_SUB_ROUND_EN
  localparam int XW = 3;
`else
  localparam int XW = 0;
`endif
  localparam int EW = EXP_WIDTH;
  localparam int FW = SIGNIFICANDS_WIDTH;
  localparam int MW = ADDER_WIDTH + XW;  // carry + hidden + fraction (+ guard/round/sticky)
  localparam int HB = FW + XW;           // hidden-bit position in the working significand

  localparam logic [EW-1:0]         EXP_MAX   = {EW{1'b1}};
  localparam logic [EW-1:0]         EXP_ZERO  = {EW{1'b0}};
  localparam logic [EW-1:0]         EXP_ONE   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0]         SHIFT_LIM = EW'(MW);
  localparam logic [MW-1:0]         MANT_ZERO = {MW{1'b0}};
  localparam logic [FW-1:0]         FRAC_ZERO = {FW{1'b0}};
  localparam logic [DATA_WIDTH-2:0] MAG_ZERO  = {(DATA_WIDTH-1){1'b0}};
  localparam logic [DATA_WIDTH-1:0] RES_ZERO  = {DATA_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ARITH = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] a_r, a_s, b_r, b_s, res_r, res_s;
  logic                  sign_r, sign_s, sub_r, sub_s;
  logic [EW-1:0]         exp_r, exp_s;
  logic [MW-1:0]         mant_r, mant_s, sml_r, sml_s;
  logic                  in_ready_r, out_valid_r, busy_r;

  logic [EW-1:0]         ea_s, eb_s, diff_s;
  logic                  a_big_s;
  logic [MW-1:0]         m_big_s, m_sml_s, al_sml_s, sum_s;
`ifdef FP_SUB_ROUND_EN
  logic                  rnd_up_s;
  logic [ADDER_WIDTH-1:0] rnd_s;
`endif

  // Pick the larger magnitude and align the smaller significand to its exponent
  always_comb begin
    ea_s    = a_r[DATA_WIDTH-2 -: EW];
    eb_s    = b_r[DATA_WIDTH-2 -: EW];
    // {exp,frac} compared as one field orders by exponent first, then fraction
    a_big_s = (a_r[DATA_WIDTH-2:0] >= b_r[DATA_WIDTH-2:0]);
    m_big_s = MANT_ZERO;
    m_sml_s = MANT_ZERO;
    m_big_s[HB] = 1'b1;
    m_sml_s[HB] = 1'b1;
    if (a_big_s) begin
      m_big_s[HB-1 -: FW] = a_r[FW-1:0];
      m_sml_s[HB-1 -: FW] = b_r[FW-1:0];
      diff_s = ea_s - eb_s;
    end else begin
      m_big_s[HB-1 -: FW] = b_r[FW-1:0];
      m_sml_s[HB-1 -: FW] = a_r[FW-1:0];
      diff_s = eb_s - ea_s;
    end
    if (diff_s >= SHIFT_LIM) begin
`ifdef FP_SUB_ROUND_EN
      al_sml_s = {{(MW-1){1'b0}}, 1'b1};  // everything lands in sticky
`else
      al_sml_s = MANT_ZERO;
`endif
    end else begin
      al_sml_s = m_sml_s >> diff_s;
`ifdef FP_SUB_ROUND_EN
      al_sml_s[0] = al_sml_s[0] | (|(m_sml_s & ~({MW{1'b1}} << diff_s)));
`endif
    end
  end

  // Next-state and datapath decode for the subtraction sequence
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    res_s   = res_r;
    sign_s  = sign_r;
    sub_s   = sub_r;
    exp_s   = exp_r;
    mant_s  = mant_r;
    sml_s   = sml_r;
    sum_s   = sub_r ? (mant_r - sml_r) : (mant_r + sml_r);
`ifdef FP_SUB_ROUND_EN
    rnd_up_s = mant_r[XW-1] & ((|mant_r[XW-2:0]) | mant_r[XW]);
    rnd_s    = {1'b0, mant_r[HB:XW]} + {{(ADDER_WIDTH-1){1'b0}}, rnd_up_s};
`endif
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          a_s     = bus.input_01;
          b_s     = {~bus.input_02[DATA_WIDTH-1], bus.input_02[DATA_WIDTH-2:0]};
          state_s = ALIGN;
        end else begin
          state_s = IDLE;
        end
      end
      ALIGN: begin
        if (ea_s == EXP_MAX) begin
          res_s   = a_r;
          state_s = DONE;
        end else if (eb_s == EXP_MAX) begin
          res_s   = b_r;
          state_s = DONE;
        end else if (a_r[DATA_WIDTH-2:0] == MAG_ZERO) begin
          res_s   = b_r;
          state_s = DONE;
        end else if (b_r[DATA_WIDTH-2:0] == MAG_ZERO) begin
          res_s   = a_r;
          state_s = DONE;
        end else begin
          sign_s  = a_big_s ? a_r[DATA_WIDTH-1] : b_r[DATA_WIDTH-1];
          sub_s   = a_r[DATA_WIDTH-1] ^ b_r[DATA_WIDTH-1];
          exp_s   = a_big_s ? ea_s : eb_s;
          mant_s  = m_big_s;
          sml_s   = al_sml_s;
          state_s = ARITH;
        end
      end
      ARITH: begin
        if (sum_s == MANT_ZERO) begin
          res_s   = RES_ZERO;  // exact cancellation is always +0
          state_s = DONE;
        end else if (sum_s[MW-1]) begin
          mant_s = sum_s >> 1;
`ifdef FP_SUB_ROUND_EN
          mant_s[0] = sum_s[1] | sum_s[0];
`endif
          if (exp_r == (EXP_MAX - EXP_ONE)) begin
            exp_s  = EXP_MAX;  // overflow to infinity: bare hidden bit, zero fraction
            mant_s = MANT_ZERO;
            mant_s[HB] = 1'b1;
          end else begin
            exp_s = exp_r + EXP_ONE;
          end
          state_s = NORM;
        end else begin
          mant_s  = sum_s;
          state_s = NORM;
        end
      end
      NORM: begin
        if (exp_r == EXP_ZERO) begin
          res_s   = {sign_r, MAG_ZERO};
          state_s = DONE;
        end else if (mant_r[HB]) begin
`ifdef FP_SUB_ROUND_EN
          state_s = ROUND;
`else
          res_s   = {sign_r, exp_r, mant_r[HB-1 -: FW]};
          state_s = DONE;
`endif
        end else if (exp_r == EXP_ONE) begin
          res_s   = {sign_r, MAG_ZERO};  // next step would underflow: flush
          state_s = DONE;
        end else begin
          mant_s  = mant_r << 1;
          exp_s   = exp_r - EXP_ONE;
          state_s = NORM;
        end
      end
      ROUND: begin
`ifdef FP_SUB_ROUND_EN
        if (exp_r == EXP_MAX) begin
          res_s = {sign_r, EXP_MAX, FRAC_ZERO};
        end else if (rnd_s[ADDER_WIDTH-1]) begin
          if (exp_r == (EXP_MAX - EXP_ONE)) begin
            res_s = {sign_r, EXP_MAX, FRAC_ZERO};
          end else begin
            res_s = {sign_r, exp_r + EXP_ONE, rnd_s[FW:1]};
          end
        end else begin
          res_s = {sign_r, exp_r, rnd_s[FW-1:0]};
        end
        state_s = DONE;
`else
        res_s   = {sign_r, EXP_MAX, FRAC_ZERO};
        state_s = IDLE;
`endif
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= RES_ZERO;
      b_r         <= RES_ZERO;
      res_r       <= RES_ZERO;
      sign_r      <= 1'b0;
      sub_r       <= 1'b0;
      exp_r       <= EXP_ZERO;
      mant_r      <= MANT_ZERO;
      sml_r       <= MANT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      a_r         <= a_s;
      b_r         <= b_s;
      res_r       <= res_s;
      sign_r      <= sign_s;
      sub_r       <= sub_s;
      exp_r       <= exp_s;
      mant_r      <= mant_s;
      sml_r       <= sml_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.busy       = busy_r;
  assign bus.result_sub = res_r;

endmodule

// File: tb/tb_fp32_sub_seq.sv
// tb_fp32_sub_seq: directed and randomized checks of fp32_sub_seq against an
// integer-arithmetic reference of the subtraction rules.
`timescale 1ns/1ps
module tb_fp32_sub_seq;
  logic clk = 1'b0;
  logic rst;

  fp32_sub_if #(.DATA_WIDTH(32)) bus ();
  fp32_sub_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FP_SUB_ROUND_EN
  localparam bit RND = 1'b1;
  localparam int SC  = 38;
  localparam int NX  = 1;
`else
  localparam bit RND = 1'b0;
  localparam int SC  = 0;
  localparam int NX  = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer significands scaled by 2^SC, aligned to the larger exponent
  function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b_raw);
    logic [31:0] b, big, sml;
    logic [63:0] ma, ml, bv, r, m, mask;
    int d, p, e, sh;
    logic sg, up, g, st;
    b = b_raw ^ 32'h8000_0000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    sg = big[31];
    d  = int'(big[30:23]) - int'(sml[30:23]);
    ma = {40'd0, 1'b1, big[22:0]} << SC;
    ml = {40'd0, 1'b1, sml[22:0]} << SC;
    if (!RND && d >= 25) bv = 64'd0;
    else if (d >= 62) bv = 64'd1;
    else begin
      bv = ml >> d;
      if (RND && ((bv << d) != ml)) bv = bv | 64'd1;
    end
    r = (a[31] != b[31]) ? ma - bv : ma + bv;
    if (r == 64'd0) return 32'd0;
    p = 63;
    while (r[p] == 1'b0) p--;
    e = int'(big[30:23]) + p - (23 + SC);
    if (e <= 0) return {sg, 31'd0};
    up = 1'b0;
    if (p >= 23) begin
      sh = p - 23;
      m  = r >> sh;
      if (RND && sh > 0) begin
        g    = r[sh-1];
        mask = (64'd1 << (sh - 1)) - 64'd1;
        st   = ((r & mask) != 64'd0);
        up   = g && (st || m[0]);
      end
    end else begin
      m = r << (23 - p);
    end
    if (up) begin
      m = m + 64'd1;
      if (m[24]) begin m = m >> 1; e++; end
    end
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    return {sg, 8'(e), m[22:0]};
  endfunction

  // One full transaction: accept, wait (bounded) for out_valid, collect, release
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int rdy_viol;
    rdy_viol = 0;
    bus.input_01 = a;
    bus.input_02 = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_viol++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) chk("timeout_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("in_ready_low_while_busy", 32'(rdy_viol), 32'd0);
    res = bus.result_sub;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [31:0] dv_a[10], dv_b[10], dv_r[10];
  int          dv_l[10];

  initial begin
    logic [31:0] res, a, b;
    int lat, wait_n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.input_01 = 32'd0;
    bus.input_02 = 32'd0;

    dv_a[0] = 32'h4040_0000; dv_b[0] = 32'h3F80_0000; dv_r[0] = 32'h4000_0000; dv_l[0] = 4 + NX;
    dv_a[1] = 32'h3F80_0000; dv_b[1] = 32'hBF80_0000; dv_r[1] = 32'h4000_0000; dv_l[1] = 4 + NX;
    dv_a[2] = 32'h3F80_0000; dv_b[2] = 32'h3F80_0000; dv_r[2] = 32'h0000_0000; dv_l[2] = 3;
    dv_a[3] = 32'h3F80_0000; dv_b[3] = 32'h3F7F_FFFF;
    dv_r[3] = RND ? 32'h3380_0000 : 32'h3400_0000;    dv_l[3] = RND ? 29 : 27;
    dv_a[4] = 32'h7FC0_0000; dv_b[4] = 32'h1234_5678; dv_r[4] = 32'h7FC0_0000; dv_l[4] = 2;
    dv_a[5] = 32'h3F80_0000; dv_b[5] = 32'h7F80_0000; dv_r[5] = 32'hFF80_0000; dv_l[5] = 2;
    dv_a[6] = 32'h0000_0000; dv_b[6] = 32'h3F80_0000; dv_r[6] = 32'hBF80_0000; dv_l[6] = 2;
    dv_a[7] = 32'h4000_0000; dv_b[7] = 32'h8000_0000; dv_r[7] = 32'h4000_0000; dv_l[7] = 2;
    dv_a[8] = 32'h7F7F_FFFF; dv_b[8] = 32'hFF7F_FFFF; dv_r[8] = 32'h7F80_0000; dv_l[8] = 4 + NX;
    dv_a[9] = 32'h0080_0000; dv_b[9] = 32'h00C0_0000; dv_r[9] = 32'h8000_0000; dv_l[9] = 4;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_result", bus.result_sub, 32'd0);

    // Directed vectors: value and accept-to-out_valid latency
    for (int i = 0; i < 10; i++) begin
      run_op(dv_a[i], dv_b[i], res, lat);
      chk($sformatf("dir%0d_result", i), res, dv_r[i]);
      chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(dv_l[i]));
      chk($sformatf("dir%0d_idle_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      chk($sformatf("dir%0d_idle_out_valid", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure: result held, no accept while out_ready stays low
    bus.input_01 = 32'h4040_0000;
    bus.input_02 = 32'h3F80_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.input_01 = 32'h3F80_0000;
    bus.input_02 = 32'h3F80_0000;
    wait_n = 0;
    while (!bus.out_valid && wait_n < 100) begin
      @(posedge clk); #1;
      wait_n++;
    end
    if (!bus.out_valid) chk("bp_timeout_out_valid", {31'd0, bus.out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_out_valid_held", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_result_held", bus.result_sub, 32'h4000_0000);
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset in the middle of a long normalisation
    bus.input_01 = 32'h3F80_0000;
    bus.input_02 = 32'h3F7F_FFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("norm_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_abort_no_late_result", {31'd0, bus.out_valid}, 32'd0);

    // Randomized operands against the reference
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 5)
        1: b[30:23] = a[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
        2: b[30:23] = a[30:23];
        3: begin
          a[30:23] = 8'($urandom_range(0, 3));
          b[30:23] = 8'($urandom_range(0, 3));
        end
        4: b = a ^ 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(a, b, res, lat);
      chk($sformatf("rand%0d_%08h_%08h", i, a, b), res, ref_sub(a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
